// File: rtl/byte_serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// byte_serial_add_ctrl_if
// Bundle of every bus signal of byte_serial_add_ctrl. The clock and reset stay
// plain ports on the module.
//   in_valid/in_ready, in_A, in_B, in_Cin  : operand-pair handshake
//   add_A, add_B, add_Cin                  : byte presented to the external adder
//   add_Sum, add_Cout                      : combinational adder result
//   out_valid/out_ready, out_Sum, out_Cout : result handshake
//   busy                                   : controller not idle
// Modport slave is used by the controller; master by whoever drives it and
// models the adder.
// ---------------------------------------------------------------------------
interface byte_serial_add_ctrl_if #(
    parameter int NBYTES = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*NBYTES-1:0]   in_A;
    logic [8*NBYTES-1:0]   in_B;
    logic                  in_Cin;

    logic [7:0]            add_A;
    logic [7:0]            add_B;
    logic                  add_Cin;
    logic [7:0]            add_Sum;
    logic                  add_Cout;

    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   out_Sum;
    logic                  out_Cout;
    logic                  busy;

    modport slave (
        input  in_valid, in_A, in_B, in_Cin, add_Sum, add_Cout, out_ready,
        output in_ready, add_A, add_B, add_Cin, out_valid, out_Sum, out_Cout, busy
    );

    modport master (
        output in_valid, in_A, in_B, in_Cin, add_Sum, add_Cout, out_ready,
        input  in_ready, add_A, add_B, add_Cin, out_valid, out_Sum, out_Cout, busy
    );
endinterface

// File: rtl/byte_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// byte_serial_add_ctrl
// Performs an unsigned 8*NBYTES-bit addition one byte per cycle using an
// external 8-bit ripple-carry adder. Byte 0 is processed first; the carry out
// of each byte is registered and fed back as the carry in of the next.
//
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : byte_serial_add_ctrl_if.slave
//          in_valid/in_ready/in_A/in_B/in_Cin     operand handshake
//          add_A/add_B/add_Cin -> add_Sum/add_Cout external adder
//          out_valid/out_ready/out_Sum/out_Cout   result handshake
//          busy                                   high outside IDLE
//
// Timing: operands accepted at edge T, bytes 0..NBYTES-1 added during the
// NBYTES cycles that follow, out_valid high from edge T+NBYTES until the
// result handshake.
// ---------------------------------------------------------------------------
module byte_serial_add_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    byte_serial_add_ctrl_if.slave bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q,     a_d;
    logic [W-1:0]    b_q,     b_d;
    logic [W-1:0]    sum_q,   sum_d;
    logic            cout_q,  cout_d;

    logic            in_add;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone
                // completes the handshake here.
                if (bus.in_valid) begin
                    a_d     = bus.in_A;
                    b_d     = bus.in_B;
                    idx_d   = '0;
                    carry_d = bus.in_Cin;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d[8*idx_q +: 8] = bus.add_Sum;
                carry_d             = bus.add_Cout;
                if (idx_q == LAST_IDX) begin
                    // Index parks on the top byte so it never runs past it.
                    cout_d  = bus.add_Cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_add = (state_q == ADD);

    // The adder inputs are forced to zero whenever no byte is being added.
    assign bus.add_A   = in_add ? a_q[8*idx_q +: 8] : 8'h00;
    assign bus.add_B   = in_add ? b_q[8*idx_q +: 8] : 8'h00;
    assign bus.add_Cin = in_add ? carry_q : 1'b0;

    // in_ready is masked while reset is held so nothing looks acceptable
    // until the block is actually running.
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_Sum   = sum_q;
    assign bus.out_Cout  = cout_q;

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
module tb_byte_serial_add_ctrl;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    byte_serial_add_ctrl_if #(.NBYTES(NB)) bus ();

    byte_serial_add_ctrl #(.NBYTES(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // External 8-bit ripple-carry adder model.
    logic [8:0] adder_res;
    assign adder_res    = {1'b0, bus.add_A} + {1'b0, bus.add_B} + {8'b0, bus.add_Cin};
    assign bus.add_Sum  = adder_res[7:0];
    assign bus.add_Cout = adder_res[8];

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard, sampled on the falling edge
    // ------------------------------------------------------------------
    int           cyc = 0;
    int           accept_cyc = 0;
    int           byte_i = 0;
    bit           in_done = 0;
    bit           post_hs = 0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         mdl_c = 1'b0;
    logic [7:0]   ea, eb;
    logic [8:0]   t9;
    logic [W:0]   full;
    exp_t         e;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            in_done = 0;
            post_hs = 0;
            byte_i  = 0;
        end else begin
            cyc++;
            if (post_hs) begin
                check_eq("idle_after_result", 64'({bus.busy, bus.out_valid, bus.in_ready}), 64'(3'b001));
                post_hs = 0;
            end
            if (bus.busy && !bus.out_valid) begin
                if (byte_i >= NB) begin
                    check_eq("add_overrun", 64'(byte_i), 64'(NB - 1));
                end else begin
                    ea = 8'(op_a >> (8 * byte_i));
                    eb = 8'(op_b >> (8 * byte_i));
                    check_eq($sformatf("add_A_byte%0d", byte_i), 64'(bus.add_A), 64'(ea));
                    check_eq($sformatf("add_B_byte%0d", byte_i), 64'(bus.add_B), 64'(eb));
                    check_eq($sformatf("add_Cin_byte%0d", byte_i), 64'(bus.add_Cin), 64'(mdl_c));
                    check_eq("in_ready_in_add", 64'(bus.in_ready), 64'(0));
                    t9    = {1'b0, ea} + {1'b0, eb} + {8'b0, mdl_c};
                    mdl_c = t9[8];
                end
                byte_i++;
            end else begin
                check_eq("add_zero_outside_add", 64'({bus.add_A, bus.add_B, bus.add_Cin}), 64'(0));
            end
            if (bus.out_valid) begin
                if (!in_done) begin
                    check_eq("latency", 64'(cyc - accept_cyc), 64'(NB + 1));
                    in_done = 1;
                end
                check_eq("in_ready_in_done", 64'(bus.in_ready), 64'(0));
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_result", 64'(1), 64'(0));
                end else begin
                    check_eq("out_Sum", 64'(bus.out_Sum), 64'(exp_q[0].sum));
                    check_eq("out_Cout", 64'(bus.out_Cout), 64'(exp_q[0].cout));
                end
                if (bus.out_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    in_done = 0;
                    post_hs = 1;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                full   = {1'b0, bus.in_A} + {1'b0, bus.in_B} + {{W{1'b0}}, bus.in_Cin};
                e.sum  = full[W-1:0];
                e.cout = full[W];
                exp_q.push_back(e);
                op_a       = bus.in_A;
                op_b       = bus.in_B;
                mdl_c      = bus.in_Cin;
                byte_i     = 0;
                accept_cyc = cyc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input bit keep);
        bit ok = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_A     = a;
        bus.in_B     = b;
        bus.in_Cin   = cin;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_eq("handshake_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_eq("idle_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bus.in_valid  = 1'b0;
        bus.in_A      = '0;
        bus.in_B      = '0;
        bus.in_Cin    = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check_eq("rst_busy", 64'(bus.busy), 64'(0));
        check_eq("rst_out_Sum", 64'(bus.out_Sum), 64'(0));
        check_eq("rst_out_Cout", 64'(bus.out_Cout), 64'(0));
        check_eq("rst_add", 64'({bus.add_A, bus.add_B, bus.add_Cin}), 64'(0));
        rst = 1'b0;
        #1;
        check_eq("in_ready_after_rst", 64'(bus.in_ready), 64'(1));

        // Basic addition and full carry ripple
        bus.out_ready = 1'b1;
        send(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        wait_idle();
        check_eq("sum_retained_idle", 64'(bus.out_Sum), 64'(32'h23456789));
        send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
        wait_idle();
        check_eq("ripple_sum", 64'({bus.out_Cout, bus.out_Sum}), 64'(33'h1_00000000));

        // Consumer back-pressure
        bus.out_ready = 1'b0;
        send(32'h80000000, 32'h80000000, 1'b0, 1'b0);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1;
                break;
            end
        end
        check_eq("hold_reached_done", 64'(ok), 64'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_out_valid", 64'(bus.out_valid), 64'(1));
            check_eq("hold_in_ready", 64'(bus.in_ready), 64'(0));
            check_eq("hold_result", 64'({bus.out_Cout, bus.out_Sum}), 64'(33'h1_00000000));
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("release_idle", 64'({bus.busy, bus.out_valid}), 64'(0));

        // Reset in the middle of an operation
        send(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b0);
        @(posedge clk); #1;
        check_eq("second_add_cycle_busy", 64'(bus.busy), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_busy", 64'(bus.busy), 64'(0));
        check_eq("abort_out_valid", 64'(bus.out_valid), 64'(0));
        check_eq("abort_out", 64'({bus.out_Cout, bus.out_Sum}), 64'(0));
        check_eq("abort_add", 64'({bus.add_A, bus.add_B, bus.add_Cin}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("in_ready_after_abort", 64'(bus.in_ready), 64'(1));
        send(32'h00000001, 32'h00000002, 1'b0, 1'b0);
        wait_idle();
        check_eq("after_abort_sum", 64'(bus.out_Sum), 64'(3));

        // Back-to-back operand pairs with in_valid held high
        send(32'hDEADBEEF, 32'h01020304, 1'b0, 1'b1);
        send(32'h0F0F0F0F, 32'hF0F0F0F1, 1'b1, 1'b0);
        wait_idle();

        // A few random operations
        for (int k = 0; k < 4; k++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
            wait_idle();
        end

        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/byte_serial_add_ctrl.md
BYTE_SERIAL_ADD_CTRL -- requirements
Module: byte_serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, giving the operand width in bytes (legal range 2..16).
REQ-002 clk  input  1  The single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  Reset, asynchronous and active-high.
REQ-004 in_valid  input  1  Operand pair offered.
REQ-005 in_ready  output  1  Block can accept an operand pair.
REQ-006 in_A  input  8*NBYTES  Operand A.
REQ-007 in_B  input  8*NBYTES  Operand B.
REQ-008 in_Cin  input  1  Carry-in to byte 0.
REQ-009 add_A  output  8  Byte of A presented to the external 8-bit ripple-carry adder.
REQ-010 add_B  output  8  Byte of B presented to the adder.
REQ-011 add_Cin  output  1  Carry presented to the adder.
REQ-012 add_Sum  input  8  Adder sum, combinational from add_A/add_B/add_Cin.
REQ-013 add_Cout  input  1  Adder carry-out, combinational.
REQ-014 out_valid  output  1  Result available.
REQ-015 out_ready  input  1  Consumer accepts result.
REQ-016 out_Sum  output  8*NBYTES  Full-width sum.
REQ-017 out_Cout  output  1  Final carry-out of the top byte.
REQ-018 busy  output  1  High in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ADD and DONE.
REQ-020 IDLE: in_ready=1; on in_valid&in_ready, the block SHALL register in_A, in_B, idx=0 and carry=in_Cin, then enter ADD.
REQ-021 ADD: combinationally add_A=A[8*idx+:8], add_B=B[8*idx+:8], add_Cin=carry.
REQ-022 ADD, each cycle: out_Sum[8*idx+:8]<=add_Sum, carry<=add_Cout, idx<=idx+1.
REQ-023 ADD: when idx==NBYTES-1, the block SHALL perform that byte's capture, set out_Cout<=add_Cout, and enter DONE; idx SHALL never exceed NBYTES-1.
REQ-024 Latency: handshake at edge T -> ADD during cycles T+1..T+NBYTES -> out_valid=1 from edge T+NBYTES (NBYTES+1 edges counting acceptance).
REQ-025 DONE: out_valid=1; out_Sum/out_Cout SHALL hold stable until out_valid&out_ready, after which the block enters IDLE and out_valid drops on the next edge.
REQ-026 in_ready SHALL be 0 in ADD and DONE; no overlap of operations; in_valid in those states SHALL be ignored.
REQ-027 Outside ADD, add_A, add_B and add_Cin SHALL be driven 0.
REQ-028 out_valid SHALL be asserted only in DONE.
REQ-029 out_Sum SHALL retain the previous result in IDLE; bytes are overwritten progressively during ADD.
REQ-030 Arithmetic SHALL be unsigned modulo 2^(8*NBYTES); overflow SHALL be reported only on out_Cout.
REQ-031 Operands SHALL be sampled only at the input handshake; later changes to in_A/in_B SHALL not affect the result in progress.
REQ-032 out_ready already high on DONE entry SHALL complete the handshake in that first DONE cycle.

Reset
REQ-033 rst=1 SHALL immediately force state=IDLE, idx=0, carry=0, out_Sum=0, out_Cout=0, out_valid=0, busy=0, add_* =0; in_ready SHALL read 1 after deassertion.
REQ-034 rst asserted in ADD or DONE SHALL abort the operation, discard the partial result, and require no further handshake.
REQ-035 After rst deasserts, the first rising edge with in_valid=1 SHALL be accepted normally.

Verification
REQ-036 NBYTES=4, A=0x12345678, B=0x11111111, Cin=0 -> out_Sum=0x23456789, out_Cout=0, out_valid at acceptance edge +4.
REQ-037 A=0xFFFFFFFF, B=0x00000000, Cin=1 -> carry ripples through all bytes; out_Sum=0x00000000, out_Cout=1.
REQ-038 A=0x80000000, B=0x80000000, Cin=0, out_ready held 0 for 5 cycles -> out_valid and out_Sum=0x00000000, out_Cout=1 stable, in_ready=0 throughout; release -> IDLE next edge.
REQ-039 rst pulsed during the 2nd ADD cycle -> all outputs 0 asynchronously, busy=0; next operation A=1, B=2 -> out_Sum=3.
REQ-040 Back-to-back: in_valid held high with two operand pairs, out_ready=1 -> second pair accepted on the edge after the first result handshake, never earlier; add_A/add_B per cycle match byte order 0..3.
